byte_to_bcd_seq: RTL

Sequential binary-to-BCD converter for the UART display path. It accepts one 8-bit byte from the UART receiver through a valid/ready handshake and converts it with an iterative shift-and-add-3 (double-dabble) datapath. It presents hundreds, tens and ones digits as 5-bit codes that drive one seven-segment digit decoder each. Leading zeros are optionally replaced by the blank code 31, which the decoder renders as all segments off.

---
 rtl/byte_to_bcd_seq_pkg.sv | 28 ++
 rtl/byte_to_bcd_seq_bcd_add3.sv | 14 +
 rtl/byte_to_bcd_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/byte_to_bcd_seq_pkg.sv
// Shared definitions for the byte-to-BCD display converter.
// Pure declarations; no logic or latency of its own.
// No flow control here; handshake lives in the top module.
package byte_to_bcd_seq_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of one seven-segment digit code
    localparam int DIG_W = 5;

    // Digit code that the segment decoder renders as all segments off
    localparam logic [DIG_W-1:0] BLANK = 5'd31;

    // One shift-and-add-3 iteration per input bit
    localparam int ITER  = 8;
    localparam int CNT_W = $clog2(ITER);

    // Zero-extend a BCD nibble into a digit code
    function automatic logic [DIG_W-1:0] dig_code(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/byte_to_bcd_seq_bcd_add3.sv
// Double-dabble correction cell: nibble >= 5 gets +3 before the shift.
// Purely combinational, zero cycles.
// No flow control.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pre-shift correction so a doubled nibble carries correctly into the next digit
    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/byte_to_bcd_seq.sv
// Iterative binary-to-BCD converter feeding three seven-segment digit decoders.
// Accept at edge E0, eight shift iterations, digits and out_valid visible after E9.
// in_ready low for 9 cycles after accept; bytes offered while busy are dropped and flagged by overrun.
module byte_to_bcd_seq
    import byte_to_bcd_seq_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [DIG_W-1:0] dig_hund,
    output logic [DIG_W-1:0] dig_tens,
    output logic [DIG_W-1:0] dig_ones,
    output logic             out_valid,
    output logic             overrun
);

    state_t             state;
    logic [7:0]         bin_q;
    logic [11:0]        bcd_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [11:0]        bcd_adj;
    logic [19:0]        shifted;
    logic               hund_zero;
    logic               tens_zero;
    logic [DIG_W-1:0]   hund_code;
    logic [DIG_W-1:0]   tens_code;

    // One correction cell per BCD digit; the hundreds cell never fires for byte inputs
    // but keeps the datapath regular.
    bcd_add3 u_add3_ones (.din(bcd_q[3:0]),  .dout(bcd_adj[3:0]));
    bcd_add3 u_add3_tens (.din(bcd_q[7:4]),  .dout(bcd_adj[7:4]));
    bcd_add3 u_add3_hund (.din(bcd_q[11:8]), .dout(bcd_adj[11:8]));

    // Corrected BCD and remaining binary bits shift left together as one register
    always_comb begin
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Leading-zero blanking; the ones digit always shows so zero reads "0"
    always_comb begin
        hund_zero = (bcd_q[11:8] == 4'd0);
        tens_zero = (bcd_q[7:4] == 4'd0);
        hund_code = (BLANK_LZ && hund_zero) ? BLANK : dig_code(bcd_q[11:8]);
        tens_code = (BLANK_LZ && hund_zero && tens_zero) ? BLANK : dig_code(bcd_q[7:4]);
    end

    // Control FSM, iteration counter, shift register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            dig_hund  <= BLANK;
            dig_tens  <= BLANK;
            dig_ones  <= BLANK;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // A byte offered while busy is lost; flag every such cycle
            overrun   <= in_valid && !in_ready;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        bin_q    <= in_data;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_q <= shifted[19:8];
                    bin_q <= shifted[7:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dig_hund  <= hund_code;
                    dig_tens  <= tens_code;
                    dig_ones  <= dig_code(bcd_q[3:0]);
                    out_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
